// File: rtl/prco_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prco_io_pkg
// Purpose  : Shared types and constants for the UART1 TX byte-path arbiter:
//            sequencer state encoding, default widths/depths and requester
//            indices used by the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
package prco_io_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Round-robin pointer values: which requester wins a tie next
  localparam logic RR_CPU = 1'b0;
  localparam logic RR_DBG = 1'b1;

  // TX sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WAIT   = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/prco_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prco_sync_fifo
// Purpose  : Single-clock FIFO with registered occupancy count. Head data is
//            presented combinationally (first-word fall-through).
// Ports    : i_clk, i_rst     clock, asynchronous active-high reset
//            i_push, i_wdata  write request and data (ignored when full)
//            i_pop            read request (ignored when empty)
//            o_rdata          data at the head of the queue
//            o_count          number of entries held
//            o_full, o_empty  occupancy flags derived from o_count
// Revision : 1.0 - initial release
// ============================================================================
module prco_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Protect the pointers against a misbehaving caller
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of 2, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/prco_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : prco_uart_tx_arb
// Purpose  : Shares the UART1 transmit byte path between the CPU store path
//            and the debug port. Granted bytes are queued in a small FIFO and
//            a sequencer issues them one at a time to the TX engine with a
//            start/busy handshake.
// Ports    : i_clk, i_rst                  clock, async active-high reset
//            i_req_cpu, i_data_cpu         CPU byte request (held until gnt)
//            q_gnt_cpu                     pulse: CPU byte captured last edge
//            i_req_dbg, i_data_dbg         debug byte request (held until gnt)
//            q_gnt_dbg                     pulse: debug byte captured last edge
//            q_tx_data, q_tx_start         byte and start pulse to TX engine
//            i_tx_busy                     TX engine shifting a byte
//            q_fifo_count, q_full, q_empty queue occupancy
//            q_idle                        sequencer idle and queue empty
// Revision : 1.0 - initial release
// ============================================================================
module prco_uart_tx_arb
  import prco_io_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_cpu,
  input  logic [DATA_W-1:0] i_data_cpu,
  output logic              q_gnt_cpu,
  input  logic              i_req_dbg,
  input  logic [DATA_W-1:0] i_data_dbg,
  output logic              q_gnt_dbg,
  output logic [DATA_W-1:0] q_tx_data,
  output logic              q_tx_start,
  input  logic              i_tx_busy,
  output logic [CNT_W-1:0]  q_fifo_count,
  output logic              q_full,
  output logic              q_empty,
  output logic              q_idle
);

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------
  logic              r_gnt_cpu;
  logic              r_gnt_dbg;
  logic              r_rr;
  logic              w_elig_cpu;
  logic              w_elig_dbg;
  logic              w_win_cpu;
  logic              w_win_dbg;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;

  // A port whose gnt is high is presenting an already-captured byte this
  // cycle, so it sits out. Full is the registered flag: a same-cycle pop
  // never makes room for a push.
  assign w_elig_cpu = i_req_cpu & ~r_gnt_cpu & ~w_full;
  assign w_elig_dbg = i_req_dbg & ~r_gnt_dbg & ~w_full;

  assign w_win_cpu = w_elig_cpu & (~w_elig_dbg | (r_rr == RR_CPU));
  assign w_win_dbg = w_elig_dbg & (~w_elig_cpu | (r_rr == RR_DBG));

  assign w_push      = w_win_cpu | w_win_dbg;
  assign w_push_data = w_win_cpu ? i_data_cpu : i_data_dbg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt_cpu <= 1'b0;
      r_gnt_dbg <= 1'b0;
      r_rr      <= RR_CPU;
    end else begin
      r_gnt_cpu <= w_win_cpu;
      r_gnt_dbg <= w_win_dbg;
      // The pointer only moves when it actually decided a tie
      if (w_elig_cpu && w_elig_dbg) begin
        r_rr <= (r_rr == RR_CPU) ? RR_DBG : RR_CPU;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte queue
  // --------------------------------------------------------------------------
  prco_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // --------------------------------------------------------------------------
  // TX sequencer
  // --------------------------------------------------------------------------
  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic              w_tx_start;
  logic [DATA_W-1:0] r_tx_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx_start  = 1'b1;
        w_state_nxt = ST_SETTLE;
      end
      // The TX engine raises busy one cycle after start; busy is not
      // trustworthy until the following cycle.
      ST_SETTLE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!i_tx_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Holds the last popped byte until the next pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_tx_data <= w_head;
    end
  end

  assign q_gnt_cpu    = r_gnt_cpu;
  assign q_gnt_dbg    = r_gnt_dbg;
  assign q_tx_data    = r_tx_data;
  assign q_tx_start   = w_tx_start;
  assign q_fifo_count = w_count;
  assign q_full       = w_full;
  assign q_empty      = w_empty;
  assign q_idle       = (r_state == ST_IDLE) & w_empty;

endmodule
`default_nettype wire

// File: tb/tb_prco_uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prco_uart_tx_arb
// Purpose  : Scoreboard bench for prco_uart_tx_arb. Requester drivers feed
//            byte queues; expected grant order and TX byte order are queued
//            when stimulus is issued and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prco_uart_tx_arb;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req_cpu = 1'b0;
  logic [DW-1:0] i_data_cpu = '0;
  logic          q_gnt_cpu;
  logic          i_req_dbg = 1'b0;
  logic [DW-1:0] i_data_dbg = '0;
  logic          q_gnt_dbg;
  logic [DW-1:0] q_tx_data;
  logic          q_tx_start;
  logic          w_tx_busy;
  logic [CW-1:0] q_fifo_count;
  logic          q_full;
  logic          q_empty;
  logic          q_idle;

  // Bench state
  logic [DW-1:0] cpu_src[$];
  logic [DW-1:0] dbg_src[$];
  logic [DW-1:0] exp_tx[$];
  logic          exp_gnt[$];   // 0 = CPU, 1 = debug
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_start = -100;
  logic          prev_gnt_cpu = 1'b0;
  logic          prev_gnt_dbg = 1'b0;
  logic          r_busy = 1'b0;
  logic          tx_hold = 1'b0;
  int            busy_len = 3;

  assign w_tx_busy = r_busy | tx_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prco_uart_tx_arb #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_cpu    (i_req_cpu),
    .i_data_cpu   (i_data_cpu),
    .q_gnt_cpu    (q_gnt_cpu),
    .i_req_dbg    (i_req_dbg),
    .i_data_dbg   (i_data_dbg),
    .q_gnt_dbg    (q_gnt_dbg),
    .q_tx_data    (q_tx_data),
    .q_tx_start   (q_tx_start),
    .i_tx_busy    (w_tx_busy),
    .q_fifo_count (q_fifo_count),
    .q_full       (q_full),
    .q_empty      (q_empty),
    .q_idle       (q_idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Requester drivers: react to gnt after each edge, present next byte
  // --------------------------------------------------------------------------
  initial forever begin
    @(posedge clk); #2;
    if (q_gnt_cpu && cpu_src.size() > 0) void'(cpu_src.pop_front());
    i_req_cpu  = (cpu_src.size() > 0);
    i_data_cpu = (cpu_src.size() > 0) ? cpu_src[0] : '0;
  end

  initial forever begin
    @(posedge clk); #2;
    if (q_gnt_dbg && dbg_src.size() > 0) void'(dbg_src.pop_front());
    i_req_dbg  = (dbg_src.size() > 0);
    i_data_dbg = (dbg_src.size() > 0) ? dbg_src[0] : '0;
  end

  // --------------------------------------------------------------------------
  // TX engine model: busy rises the cycle after start, lasts busy_len cycles
  // --------------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (q_tx_start && !rst) begin
      @(posedge clk); #1 r_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 r_busy = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      last_start   = -100;
      prev_gnt_cpu = 1'b0;
      prev_gnt_dbg = 1'b0;
    end else begin
      if (q_tx_start) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_tx_start: got data 0x%0h, expected no start (t=%0t)", q_tx_data, $time);
        end else begin
          check("tx_data_order", q_tx_data, exp_tx.pop_front());
        end
        if (last_start > -100) check("tx_start_spacing_ge4", (cyc - last_start) >= 4, 1);
        last_start = cyc;
      end
      if (q_gnt_cpu && q_gnt_dbg) fail_now("both_gnt_high");
      if (q_gnt_cpu) begin
        if (exp_gnt.size() == 0) fail_now("unexpected_gnt_cpu");
        else check("gnt_order_cpu", 0, exp_gnt.pop_front());
        check("gnt_cpu_not_consecutive", prev_gnt_cpu, 0);
      end
      if (q_gnt_dbg) begin
        if (exp_gnt.size() == 0) fail_now("unexpected_gnt_dbg");
        else check("gnt_order_dbg", 1, exp_gnt.pop_front());
        check("gnt_dbg_not_consecutive", prev_gnt_dbg, 0);
      end
      check("full_flag", q_full, q_fifo_count == CW'(DEPTH));
      check("empty_flag", q_empty, q_fifo_count == '0);
      prev_gnt_cpu = q_gnt_cpu;
      prev_gnt_dbg = q_gnt_dbg;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},    q_fifo_count, 0);
    check({tag, "_empty"},    q_empty, 1);
    check({tag, "_full"},     q_full, 0);
    check({tag, "_idle"},     q_idle, 1);
    check({tag, "_tx_data"},  q_tx_data, 0);
    check({tag, "_tx_start"}, q_tx_start, 0);
    check({tag, "_gnt"},      {q_gnt_cpu, q_gnt_dbg}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst     = 1'b1;
    tx_hold = 1'b0;
    cpu_src.delete();
    dbg_src.delete();
    exp_tx.delete();
    exp_gnt.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #3;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int  k;
    logic done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      @(posedge clk); #3;
      k++;
      done = (exp_tx.size() == 0) && (exp_gnt.size() == 0) && (cpu_src.size() == 0) &&
             (dbg_src.size() == 0) && q_idle && !w_tx_busy;
    end
    check({name, "_drained"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin : main
    int   k;
    logic seen;

    // Reset state, sampled before any clock edge to show async behaviour
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #3;

    // Test 1: single byte and its latency
    cpu_src.push_back(8'h41);
    exp_gnt.push_back(1'b0);
    exp_tx.push_back(8'h41);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk); #3;
      k++;
      seen = q_gnt_cpu;
    end
    check("t1_gnt_seen", seen, 1);
    check("t1_count_after_capture", q_fifo_count, 1);
    check("t1_no_start_yet", q_tx_start, 0);
    @(posedge clk); #3;
    check("t1_count_after_pop", q_fifo_count, 0);
    check("t1_tx_start", q_tx_start, 1);
    check("t1_tx_data", q_tx_data, 8'h41);
    wait_drain("t1", 50);
    check("t1_idle", q_idle, 1);
    check("t1_tx_data_held", q_tx_data, 8'h41);

    // Test 2: simultaneous requests, CPU first after reset
    do_reset();
    cpu_src.push_back(8'h10);
    dbg_src.push_back(8'h20);
    exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b1);
    exp_tx.push_back(8'h10);
    exp_tx.push_back(8'h20);
    wait_drain("t2", 60);

    // Test 3: back-pressure with the TX engine held busy
    do_reset();
    tx_hold = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cpu_src.push_back(DW'(i));
      exp_gnt.push_back(1'b0);
      exp_tx.push_back(DW'(i));
    end
    k = 0;
    while (!q_full && k < 60) begin
      @(posedge clk); #3;
      k++;
    end
    check("t3_full", q_full, 1);
    check("t3_count_full", q_fifo_count, 4);
    repeat (4) @(posedge clk);
    #3;
    check("t3_06_07_not_granted", cpu_src.size(), 2);
    check("t3_still_full", q_full, 1);
    tx_hold = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk); #3;
      k++;
      seen = q_tx_start;
    end
    check("t3_02_start_seen", seen, 1);
    check("t3_count_after_pop", q_fifo_count, 3);
    check("t3_no_gnt_on_pop_edge", q_gnt_cpu, 0);
    @(posedge clk); #3;
    check("t3_06_gnt_next_edge", q_gnt_cpu, 1);
    check("t3_count_refilled", q_fifo_count, 4);
    wait_drain("t3", 200);

    // Test 4: fairness under continuous requests from both ports
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cpu_src.push_back(8'hC0 + DW'(i));
      dbg_src.push_back(8'hD0 + DW'(i));
      exp_gnt.push_back(1'b0);
      exp_gnt.push_back(1'b1);
      exp_tx.push_back(8'hC0 + DW'(i));
      exp_tx.push_back(8'hD0 + DW'(i));
    end
    wait_drain("t4", 200);

    // Test 5: reset while bytes are queued and the sequencer waits on busy
    do_reset();
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_src.push_back(8'h51 + DW'(i));
      exp_gnt.push_back(1'b0);
    end
    exp_tx.push_back(8'h51);
    k = 0;
    while (!(q_fifo_count == 3 && cpu_src.size() == 0) && k < 40) begin
      @(posedge clk); #3;
      k++;
    end
    check("t5_three_queued", q_fifo_count, 3);
    @(negedge clk); #1 rst = 1'b1;
    #1 check_reset_outputs("t5_async");
    tx_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("t5_count_after", q_fifo_count, 0);
    check("t5_idle_after", q_idle, 1);
    check("t5_tx_data_after", q_tx_data, 0);

    // Test 6: pointer wrap, ten bytes from the debug port
    do_reset();
    busy_len = 3;
    for (int i = 0; i < 10; i++) begin
      dbg_src.push_back(8'hA0 + DW'(i));
      exp_gnt.push_back(1'b1);
      exp_tx.push_back(8'hA0 + DW'(i));
    end
    wait_drain("t6", 400);
    check("t6_last_byte", q_tx_data, 8'hA9);

    check("end_exp_tx_empty", exp_tx.size(), 0);
    check("end_exp_gnt_empty", exp_gnt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
